conv_layer_sequencer: RTL and testbench

Top-level scheduler for one convolution layer. It splits the layer's output channels into weight tiles and runs each tile through three phases: weight load, compute and write-back. Two weight banks are used in ping-pong, so the load of tile t+1 overlaps the compute and write-back of tile t. The block sits between the layer-config registers and three engines: the weight loader, the compute control and the output writer. It talks to each engine with a start/done pulse pair.

---
 rtl/conv_layer_sequencer_if.sv | 34 +++
 rtl/conv_layer_sequencer.sv | 175 +++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sequencer_if.sv
// Start/done handshake bundle between the layer sequencer, the layer-config
// registers and the weight-loader / compute / output-writer engines.
interface conv_layer_sequencer_if #(
  parameter int unsigned WIDTH_TILE_CNT = 8
);
  logic                      start;
  logic [WIDTH_TILE_CNT-1:0] cfg_tile_num;
  logic                      busy;
  logic                      layer_done;
  logic                      load_start;
  logic                      load_bank;
  logic [WIDTH_TILE_CNT-1:0] load_tile;
  logic                      load_done;
  logic                      cu_start;
  logic                      cu_bank;
  logic                      cu_done;
  logic                      wb_start;
  logic                      wb_done;
  logic [WIDTH_TILE_CNT-1:0] tile_idx;

  // Sequencer side
  modport master (
    input  start, cfg_tile_num, load_done, cu_done, wb_done,
    output busy, layer_done, load_start, load_bank, load_tile,
           cu_start, cu_bank, wb_start, tile_idx
  );

  // Config registers and engines side
  modport slave (
    output start, cfg_tile_num, load_done, cu_done, wb_done,
    input  busy, layer_done, load_start, load_bank, load_tile,
           cu_start, cu_bank, wb_start, tile_idx
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Convolution layer scheduler: runs weight tiles through load, compute and
// write-back, prefetching the next tile into the idle weight bank.
module conv_layer_sequencer #(
  parameter int unsigned WIDTH_TILE_CNT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_layer_sequencer_if.master bus
);
  localparam int unsigned W  = WIDTH_TILE_CNT;
  localparam int unsigned WE = WIDTH_TILE_CNT + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_FIRST, S_COMPUTE, S_WRITEBACK, S_WAIT_LOAD, S_FINISH
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   tile_idx_q, tile_idx_d;
  logic [W-1:0]   load_tile_q, load_tile_d;
  logic           load_bank_q, load_bank_d;
  logic           cu_bank_q, cu_bank_d;
  logic           load_pend_q, load_pend_d;
  logic           busy_q, busy_d;
  logic           layer_done_q, layer_done_d;
  logic           load_start_q, load_start_d;
  logic           cu_start_q, cu_start_d;
  logic           wb_start_q, wb_start_d;

  logic           enter_cu;
  logic [W-1:0]   enter_tile;
  logic           enter_bank;
  logic [WE-1:0]  cnt_ext;
  logic [WE-1:0]  tile_nxt;
  logic [WE-1:0]  pre_tile;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tile_idx_d   = tile_idx_q;
    load_tile_d  = load_tile_q;
    load_bank_d  = load_bank_q;
    cu_bank_d    = cu_bank_q;
    load_pend_d  = load_pend_q;
    busy_d       = busy_q;
    layer_done_d = 1'b0;
    load_start_d = 1'b0;
    cu_start_d   = 1'b0;
    wb_start_d   = 1'b0;
    enter_cu     = 1'b0;
    enter_tile   = tile_idx_q;
    enter_bank   = ~cu_bank_q;
    // Extra bit keeps count = 2^W-1 from wrapping in the compares
    cnt_ext      = {1'b0, cnt_q};
    tile_nxt     = {1'b0, tile_idx_q} + WE'(1);
    pre_tile     = '0;

    if (bus.load_done) load_pend_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.cfg_tile_num == '0) begin
            layer_done_d = 1'b1;
            state_d      = S_FINISH;
          end else begin
            cnt_d        = bus.cfg_tile_num;
            tile_idx_d   = '0;
            cu_bank_d    = 1'b0;
            load_start_d = 1'b1;
            load_bank_d  = 1'b0;
            load_tile_d  = '0;
            load_pend_d  = 1'b1;
            state_d      = S_LOAD_FIRST;
          end
        end
      end
      S_LOAD_FIRST: begin
        if (bus.load_done) begin
          enter_cu   = 1'b1;
          enter_tile = '0;
          enter_bank = 1'b0;
        end
      end
      S_COMPUTE: begin
        if (bus.cu_done) begin
          wb_start_d = 1'b1;
          state_d    = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (bus.wb_done) begin
          if (tile_nxt == cnt_ext) begin
            layer_done_d = 1'b1;
            state_d      = S_FINISH;
          end else if (!load_pend_q || bus.load_done) begin
            enter_cu   = 1'b1;
            enter_tile = W'(tile_nxt);
          end else begin
            state_d = S_WAIT_LOAD;
          end
        end
      end
      S_WAIT_LOAD: begin
        if (bus.load_done) begin
          enter_cu   = 1'b1;
          enter_tile = W'(tile_nxt);
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every compute entry prefetches the following tile into the other bank
    if (enter_cu) begin
      state_d    = S_COMPUTE;
      tile_idx_d = enter_tile;
      cu_bank_d  = enter_bank;
      cu_start_d = 1'b1;
      pre_tile   = {1'b0, enter_tile} + WE'(1);
      if (pre_tile < cnt_ext) begin
        load_start_d = 1'b1;
        load_bank_d  = ~enter_bank;
        load_tile_d  = W'(pre_tile);
        load_pend_d  = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tile_idx_q   <= '0;
      load_tile_q  <= '0;
      load_bank_q  <= 1'b0;
      cu_bank_q    <= 1'b0;
      load_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      load_start_q <= 1'b0;
      cu_start_q   <= 1'b0;
      wb_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tile_idx_q   <= tile_idx_d;
      load_tile_q  <= load_tile_d;
      load_bank_q  <= load_bank_d;
      cu_bank_q    <= cu_bank_d;
      load_pend_q  <= load_pend_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
      load_start_q <= load_start_d;
      cu_start_q   <= cu_start_d;
      wb_start_q   <= wb_start_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.layer_done = layer_done_q;
  assign bus.load_start = load_start_q;
  assign bus.load_bank  = load_bank_q;
  assign bus.load_tile  = load_tile_q;
  assign bus.cu_start   = cu_start_q;
  assign bus.cu_bank    = cu_bank_q;
  assign bus.wb_start   = wb_start_q;
  assign bus.tile_idx   = tile_idx_q;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: latency-programmable engine responders, a
// tile-level reference model compared every cycle, and directed scenarios.
module tb_conv_layer_sequencer;
  localparam int unsigned W = 8;
  localparam int P_IDLE = 0, P_LF = 1, P_CU = 2, P_WB = 3, P_WL = 4, P_FIN = 5;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  conv_layer_sequencer_if #(.WIDTH_TILE_CNT(W)) bus ();
  conv_layer_sequencer #(.WIDTH_TILE_CNT(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin cyc = 0; forever begin @(posedge clk); cyc++; end end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_q(input string name, input int q[$], input int idx, input int exp);
    chk(name, (idx < q.size()) ? q[idx] : -1, exp);
  endtask

  // Tile-level reference model: tile k always loads into bank k%2 and
  // computes from bank k%2; a load is pending while issued > landed.
  int ph, m_cnt, m_t, m_last, m_iss, m_land;
  bit e_busy, e_ld, e_ls, e_cs, e_ws, model_ok, ld_ok;

  task automatic m_issue(input int k);
    e_ls = 1; m_last = k; m_iss = k + 1;
  endtask

  task automatic m_compute(input int k);
    m_t = k; e_cs = 1; ph = P_CU;
    if (k + 1 < m_cnt) m_issue(k + 1);
  endtask

  initial begin
    model_ok = 0; ph = P_IDLE; m_cnt = 0; m_t = 0; m_last = 0; m_iss = 0; m_land = 0;
    e_busy = 0; e_ld = 0; e_ls = 0; e_cs = 0; e_ws = 0;
    forever begin
      @(posedge clk);
      e_ls = 0; e_cs = 0; e_ws = 0; e_ld = 0;
      if (rst) begin
        ph = P_IDLE; e_busy = 0; m_t = 0; m_last = 0; m_iss = 0; m_land = 0; m_cnt = 0;
        model_ok = 1;
      end else begin
        ld_ok = bus.load_done && (m_iss > m_land);
        if (ld_ok) m_land++;
        case (ph)
          P_IDLE: if (bus.start) begin
            e_busy = 1;
            if (bus.cfg_tile_num == 0) begin ph = P_FIN; e_ld = 1; end
            else begin
              m_cnt = int'(bus.cfg_tile_num); m_t = 0; m_iss = 0; m_land = 0;
              m_issue(0); ph = P_LF;
            end
          end
          P_LF:  if (ld_ok) m_compute(0);
          P_CU:  if (bus.cu_done) begin e_ws = 1; ph = P_WB; end
          P_WB:  if (bus.wb_done) begin
            if (m_t == m_cnt - 1) begin ph = P_FIN; e_ld = 1; end
            else if (m_land >= m_t + 2) m_compute(m_t + 1);
            else ph = P_WL;
          end
          P_WL:  if (ld_ok) m_compute(m_t + 1);
          P_FIN: begin e_busy = 0; ph = P_IDLE; end
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("busy",       bus.busy,       e_busy);
        chk("layer_done", bus.layer_done, e_ld);
        chk("load_start", bus.load_start, e_ls);
        chk("load_tile",  bus.load_tile,  m_last);
        chk("load_bank",  bus.load_bank,  m_last % 2);
        chk("cu_start",   bus.cu_start,   e_cs);
        chk("cu_bank",    bus.cu_bank,    m_t % 2);
        chk("wb_start",   bus.wb_start,   e_ws);
        chk("tile_idx",   bus.tile_idx,   m_t);
      end
    end
  end

  // Engine responders and pulse statistics
  int ll_lo, ll_hi, lc_lo, lc_hi, lw_lo, lw_hi, lat_t1;
  int load_t, cu_t, wb_t;
  bit stray_en, stray_ld;
  int n_ls, n_cs, n_ws, n_ld, last_wb, last_ld;
  int q_lt[$], q_lb[$], q_ti[$], q_cb[$], gap_wb[$], gap_ld[$];

  task automatic clear_stats();
    n_ls = 0; n_cs = 0; n_ws = 0; n_ld = 0; last_wb = -1000; last_ld = -1000;
    q_lt.delete(); q_lb.delete(); q_ti.delete(); q_cb.delete();
    gap_wb.delete(); gap_ld.delete();
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d,
                         input int e, input int f, input int t1);
    ll_lo = a; ll_hi = b; lc_lo = c; lc_hi = d; lw_lo = e; lw_hi = f; lat_t1 = t1;
  endtask

  initial begin
    load_t = 0; cu_t = 0; wb_t = 0; stray_ld = 0;
    bus.load_done = 1'b0; bus.cu_done = 1'b0; bus.wb_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.load_done = 1'b0; bus.cu_done = 1'b0; bus.wb_done = 1'b0;
      if (rst) begin
        load_t = 0; cu_t = 0; wb_t = 0;
      end else begin
        if (load_t > 0) begin load_t--; if (load_t == 0) begin bus.load_done = 1'b1; last_ld = cyc; end end
        if (cu_t > 0)   begin cu_t--;   if (cu_t == 0)   bus.cu_done = 1'b1; end
        if (wb_t > 0)   begin wb_t--;   if (wb_t == 0)   begin bus.wb_done = 1'b1; last_wb = cyc; end end
        if (bus.load_start) begin
          n_ls++; q_lt.push_back(int'(bus.load_tile)); q_lb.push_back(int'(bus.load_bank));
          load_t = (bus.load_tile == 1 && lat_t1 > 0) ? lat_t1 : int'($urandom_range(ll_hi, ll_lo));
        end
        if (bus.cu_start) begin
          n_cs++; q_ti.push_back(int'(bus.tile_idx)); q_cb.push_back(int'(bus.cu_bank));
          gap_wb.push_back(cyc - last_wb); gap_ld.push_back(cyc - last_ld);
          cu_t = int'($urandom_range(lc_hi, lc_lo));
        end
        if (bus.wb_start) begin n_ws++; wb_t = int'($urandom_range(lw_hi, lw_lo)); end
        if (bus.layer_done) n_ld++;
        // Stray done pulses only where that engine has nothing outstanding
        if (load_t == 0 && !bus.load_done && (stray_ld || (stray_en && $urandom_range(0, 15) == 0))) begin
          bus.load_done = 1'b1; stray_ld = 0;
        end
        if (stray_en && cu_t == 0 && !bus.cu_done && $urandom_range(0, 15) == 0) bus.cu_done = 1'b1;
        if (stray_en && wb_t == 0 && !bus.wb_done && $urandom_range(0, 15) == 0) bus.wb_done = 1'b1;
      end
    end
  end

  task automatic run_layer(input int cnt, input bit extra, input bit stray_at15);
    bit seen;
    clear_stats();
    bus.start = 1'b1; bus.cfg_tile_num = W'(cnt);
    @(negedge clk);
    bus.start = 1'b0; bus.cfg_tile_num = W'($urandom);
    seen = 0;
    for (int k = 0; k < 6000 && !seen; k++) begin
      if (bus.layer_done) seen = 1;
      else begin
        if (extra && k == 3) begin bus.start = 1'b1; bus.cfg_tile_num = W'($urandom_range(1, 9)); end
        if (stray_at15 && k == 15) stray_ld = 1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    chk("layer_done_timeout", seen, 1);
    @(negedge clk);
  endtask

  initial begin
    errors = 0; checks = 0; stray_en = 0;
    set_lat(5, 5, 5, 5, 5, 5, 0);
    rst = 1'b1; bus.start = 1'b0; bus.cfg_tile_num = '0;
    clear_stats();
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_load_start", bus.load_start, 0);
    chk("rst_tile_idx", bus.tile_idx, 0);
    chk("rst_cu_bank", bus.cu_bank, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single tile, all engines 5 cycles
    run_layer(1, 0, 0);
    chk("t1_n_load", n_ls, 1); chk("t1_n_cu", n_cs, 1);
    chk("t1_n_wb", n_ws, 1);   chk("t1_n_done", n_ld, 1);
    chk_q("t1_cu_bank", q_cb, 0, 0);

    // Three tiles, fast loads, extra start while busy, stray load_done in compute
    set_lat(2, 2, 20, 20, 10, 10, 0);
    run_layer(3, 1, 1);
    chk("t3_n_load", n_ls, 3); chk("t3_n_done", n_ld, 1);
    for (int i = 0; i < 3; i++) begin
      chk_q("t3_load_tile", q_lt, i, i);
      chk_q("t3_load_bank", q_lb, i, i % 2);
      chk_q("t3_tile_idx", q_ti, i, i);
      chk_q("t3_cu_bank", q_cb, i, i % 2);
    end
    chk_q("t3_cu_after_wb1", gap_wb, 1, 1);
    chk_q("t3_cu_after_wb2", gap_wb, 2, 1);

    // Two tiles, second load lands 30 cycles after wb_done
    set_lat(3, 3, 5, 5, 5, 5, 41);
    run_layer(2, 0, 0);
    chk_q("wl_cu_after_load", gap_ld, 1, 1);
    chk_q("wl_cu_after_wb", gap_wb, 1, 31);

    // Two tiles, load_done and wb_done in the same cycle
    set_lat(3, 3, 5, 5, 5, 5, 11);
    run_layer(2, 0, 0);
    chk_q("same_cu_after_wb", gap_wb, 1, 1);
    chk_q("same_cu_after_load", gap_ld, 1, 1);

    // Zero tiles; a start during the finish cycle is ignored
    clear_stats();
    bus.start = 1'b1; bus.cfg_tile_num = '0;
    @(negedge clk);
    chk("z_layer_done", bus.layer_done, 1); chk("z_busy", bus.busy, 1);
    bus.start = 1'b1; bus.cfg_tile_num = W'(4);
    @(negedge clk);
    bus.start = 1'b0;
    chk("z_busy_after", bus.busy, 0); chk("z_no_load", bus.load_start, 0);
    @(negedge clk);
    chk("z_pulses", n_ls + n_cs + n_ws, 0); chk("z_n_done", n_ld, 1);

    // Reset in the middle of tile 1 of 3 compute, then a fresh layer
    set_lat(3, 3, 6, 6, 4, 4, 0);
    bus.start = 1'b1; bus.cfg_tile_num = W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 500 && !(ph == P_CU && m_t == 1); k++) @(negedge clk);
    chk("rst_reach_tile1", int'(ph == P_CU && m_t == 1), 1);
    rst = 1'b1;
    @(negedge clk);
    clear_stats();
    chk("mr_busy", bus.busy, 0);       chk("mr_layer_done", bus.layer_done, 0);
    chk("mr_load_start", bus.load_start, 0); chk("mr_cu_start", bus.cu_start, 0);
    chk("mr_wb_start", bus.wb_start, 0);     chk("mr_tile_idx", bus.tile_idx, 0);
    chk("mr_load_tile", bus.load_tile, 0);   chk("mr_load_bank", bus.load_bank, 0);
    chk("mr_cu_bank", bus.cu_bank, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mr_no_done", n_ld, 0); chk("mr_no_pulse", n_ls + n_cs + n_ws, 0);
    run_layer(3, 0, 0);
    chk("mr_fresh_done", n_ld, 1); chk("mr_fresh_loads", n_ls, 3);

    // Randomized layers with stray done pulses and starts while busy
    stray_en = 1;
    for (int r = 0; r < 8; r++) begin
      set_lat(1, int'($urandom_range(1, 30)), 1, int'($urandom_range(1, 15)),
              1, int'($urandom_range(1, 15)), 0);
      run_layer(int'($urandom_range(1, 6)), 1, 0);
      chk("rnd_n_done", n_ld, 1);
    end

    // Largest tile count must not wrap the tile compare
    set_lat(1, 2, 1, 2, 1, 2, 0);
    run_layer(255, 1, 0);
    chk("max_n_load", n_ls, 255); chk("max_n_cu", n_cs, 255);
    chk("max_n_wb", n_ws, 255);   chk_q("max_last_tile", q_ti, 254, 254);
    stray_en = 0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
